// File: rtl/pipe_reg_asg.sv
// pipe_reg_asg: elastic WIDTH x DEPTH pipeline register with per-stage valid
// bits, valid/ready backpressure, bubble collapse, synchronous flush and an
// occupancy count.
// Optional build macro ASG_PIPE_SCAN_EN adds a scan chain (SE/SI/SO) through
// every valid and data flip-flop.
module pipe_reg_asg #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CP,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    input  logic             FLUSH,
    output logic [CNTW-1:0]  CNT
`ifdef ASG_PIPE_SCAN_EN
    ,
    input  logic             SE,
    input  logic             SI,
    output logic             SO
`endif
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_nxt;
    logic [CNTW-1:0]             cnt_q;
    logic [CNTW-1:0]             cnt_nxt;
    logic [DEPTH-1:0]            ld;

    // A stage can load when it is empty or when the stage ahead can take its content.
    always_comb begin
        ld = '0;
        ld[DEPTH-1] = ~v_q[DEPTH-1] | QR;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            ld[i] = ~v_q[i] | ld[i+1];
        end
    end

    // Upstream ready: stage 0 can take a word and no flush (or scan shift) is pending.
    always_comb begin
        DR = ld[0] & ~FLUSH;
`ifdef ASG_PIPE_SCAN_EN
        if (SE) begin
            DR = 1'b0;
        end
`endif
    end

    // Next state: scan shift, flush, or per-stage advance with data gated on incoming valid.
    always_comb begin
        v_nxt   = v_q;
        d_nxt   = d_q;
        cnt_nxt = '0;
`ifdef ASG_PIPE_SCAN_EN
        if (SE) begin
            v_nxt[0] = SI;
            for (int i = 1; i < int'(DEPTH); i++) begin
                v_nxt[i] = d_q[i-1][WIDTH-1];
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_nxt[i][0] = v_q[i];
                for (int j = 1; j < int'(WIDTH); j++) begin
                    d_nxt[i][j] = d_q[i][j-1];
                end
            end
        end else
`endif
        begin
            if (FLUSH) begin
                v_nxt = '0;
            end else begin
                if (ld[0]) begin
                    v_nxt[0] = DV;
                    if (DV) begin
                        d_nxt[0] = D;
                    end
                end
                for (int i = 1; i < int'(DEPTH); i++) begin
                    if (ld[i]) begin
                        v_nxt[i] = v_q[i-1];
                        if (v_q[i-1]) begin
                            d_nxt[i] = d_q[i-1];
                        end
                    end
                end
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_nxt = cnt_nxt + CNTW'(v_nxt[i]);
        end
    end

    // Stage registers and occupancy count.
    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            v_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_nxt;
            d_q   <= d_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign Q   = d_q[DEPTH-1];
    assign QV  = v_q[DEPTH-1];
    assign CNT = cnt_q;
`ifdef ASG_PIPE_SCAN_EN
    assign SO  = d_q[DEPTH-1][WIDTH-1];
`endif

endmodule

// File: tb/tb_pipe_reg_asg.sv
// Self-checking bench for pipe_reg_asg (default build, WIDTH=8, DEPTH=4).
// Reference model: a queue of in-flight entries, each with its stage position.
module tb_pipe_reg_asg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);

    logic             CP;
    logic             RN;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic             DR;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic             QR;
    logic             FLUSH;
    logic [CNTW-1:0]  CNT;

    int checks = 0;
    int errors = 0;

    // Model state
    int               pos[$];
    logic [WIDTH-1:0] dat[$];
    logic [WIDTH-1:0] q_last;
    bit               last_dr;

    pipe_reg_asg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CP(CP), .RN(RN), .D(D), .DV(DV), .DR(DR),
        .Q(Q), .QV(QV), .QR(QR), .FLUSH(FLUSH), .CNT(CNT)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Would a word offered now be accepted at the coming edge?
    function automatic bit model_dr(input bit qr, input bit fl);
        int limit = DEPTH;
        int np;
        if (fl) return 1'b0;
        for (int k = 0; k < pos.size(); k++) begin
            if (k == 0 && pos[0] == int'(DEPTH) - 1 && qr) begin
                limit = DEPTH;
            end else begin
                np = (pos[k] + 1 < limit) ? pos[k] + 1 : pos[k];
                limit = np;
            end
        end
        return limit > 0;
    endfunction

    task automatic model_step(input bit acc, input logic [WIDTH-1:0] din, input bit qr, input bit fl);
        int limit = DEPTH;
        if (fl) begin
            pos.delete();
            dat.delete();
            return;
        end
        if (pos.size() > 0 && pos[0] == int'(DEPTH) - 1 && qr) begin
            void'(pos.pop_front());
            void'(dat.pop_front());
        end
        for (int k = 0; k < pos.size(); k++) begin
            if (pos[k] + 1 < limit) begin
                pos[k] = pos[k] + 1;
                if (pos[k] == int'(DEPTH) - 1) q_last = dat[k];
            end
            limit = pos[k];
        end
        if (acc) begin
            pos.push_back(0);
            dat.push_back(din);
            if (DEPTH == 1) q_last = din;
        end
    endtask

    task automatic model_reset();
        pos.delete();
        dat.delete();
        q_last = '0;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_qv;
        exp_qv = (pos.size() > 0) && (pos[0] == int'(DEPTH) - 1);
        check({tag, "_qv"}, 32'(QV), 32'(exp_qv));
        check({tag, "_q"}, 32'(Q), 32'(q_last));
        check({tag, "_cnt"}, 32'(CNT), 32'(pos.size()));
    endtask

    // One clock cycle: drive, check DR, clock, update model, check outputs.
    task automatic cyc(input bit dv_i, input logic [WIDTH-1:0] d_i, input bit qr_i, input bit fl_i);
        bit exp_dr;
        DV = dv_i; D = d_i; QR = qr_i; FLUSH = fl_i;
        #1;
        exp_dr = model_dr(qr_i, fl_i);
        check("dr", 32'(DR), 32'(exp_dr));
        last_dr = exp_dr;
        @(posedge CP);
        model_step(dv_i && exp_dr, d_i, qr_i, fl_i);
        #1;
        check_outputs("cyc");
    endtask

    initial begin
        int idx;
        RN = 1'b0; DV = 1'b0; D = '0; QR = 1'b0; FLUSH = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        check("reset_dr", 32'(DR), 32'd1);
        @(posedge CP); #1;
        RN = 1'b1;

        // Streaming 0x01..0x10 with QR held high, then drain
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, WIDTH'(i), 1'b1, 1'b0);
            check("stream_dr", 32'(last_dr), 32'd1);
            if (i == 4) check("latency_q", 32'(Q), 32'h01);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_cnt", 32'(CNT), 32'd0);

        // Backpressure until full
        idx = 0;
        for (int i = 0; i < 12 && idx < 4; i++) begin
            cyc(1'b1, 8'hA0 + WIDTH'(idx), 1'b0, 1'b0);
            if (last_dr) idx++;
        end
        check("full_cnt", 32'(CNT), 32'd4);
        cyc(1'b1, 8'hA4, 1'b0, 1'b0);
        check("full_dr", 32'(last_dr), 32'd0);
        cyc(1'b1, 8'hA4, 1'b1, 1'b0);
        check("full_adv_dr", 32'(last_dr), 32'd1);
        check("full_adv_cnt", 32'(CNT), 32'd4);
        check("full_adv_q", 32'(Q), 32'hA1);

        // Flush collision: empty the pipe, fill 3 entries, then flush with DV and QR
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + WIDTH'(i), 1'b0, 1'b0);
        check("pre_flush_cnt", 32'(CNT), 32'd3);
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        check("flush_dr", 32'(last_dr), 32'd0);
        check("flush_cnt", 32'(CNT), 32'd0);
        check("flush_qv", 32'(QV), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush_after_cnt", 32'(CNT), 32'd0);

        // Bubble collapse with stalled output
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_cnt", 32'(CNT), 32'd2);
        check("bubble_q", 32'(Q), 32'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("bubble_q2", 32'(Q), 32'h22);
        check("bubble_qv2", 32'(QV), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("bubble_empty", 32'(CNT), 32'd0);

        // Asynchronous reset mid-stream with three entries held
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(CNT), 32'd3);
        #2;
        RN = 1'b0;
        #1;
        model_reset();
        check("arst_qv", 32'(QV), 32'd0);
        check("arst_q", 32'(Q), 32'd0);
        check("arst_cnt", 32'(CNT), 32'd0);
        @(posedge CP); #1;
        RN = 1'b1;
        DV = 1'b0; QR = 1'b0; FLUSH = 1'b0;
        #1;
        check("post_rst_dr", 32'(DR), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), WIDTH'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
